// File: rtl/adc0808_pkg.sv
// Shared ADC0808 bus constants and responder state encoding.
// Used by the responder, the controller and their benches.
package adc0808_pkg;

    localparam int ADC_ADDR_W      = 3;
    localparam int ADC_DATA_W      = 8;
    localparam int ADC_CONV_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CONVERT
    } adc_state_e;

endpackage

// File: rtl/adc0808_responder_if.sv
// ADC0808 converter bus: controller drives ALE/START/OE/ADDR,
// device drives EOC and the result bus.
interface adc0808_responder_if;
    import adc0808_pkg::*;

    logic                  ale;
    logic                  start;
    logic                  oe;
    logic [ADC_ADDR_W-1:0] addr;
    logic                  eoc;
    logic [ADC_DATA_W-1:0] data_out;
    logic                  data_drv;

    modport master (
        output ale, start, oe, addr,
        input  eoc, data_out, data_drv
    );

    modport slave (
        input  ale, start, oe, addr,
        output eoc, data_out, data_drv
    );

endinterface

// File: rtl/adc_edge_detect.sv
// Registered previous-value flop giving one-cycle rise/fall
// strobes for a single clk-synchronous bit.
module adc_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= i_d;
    end

    assign o_rise = i_d & ~r_prev;
    assign o_fall = ~i_d & r_prev;

endmodule

// File: rtl/adc0808_responder.sv
// ADC0808 device-side emulation: latches the channel address,
// runs a timed conversion and presents EOC plus the result.
module adc0808_responder
    import adc0808_pkg::*;
#(
    parameter int CONV_CYCLES = ADC_CONV_CYCLES,
    parameter int CH_COUNT    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    adc0808_responder_if.slave             bus,
    input  logic [CH_COUNT*ADC_DATA_W-1:0] ch_data,
    output logic                           conv_done
);

    localparam int CNT_W = $clog2(CONV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

    logic                  w_ale_rise;
    logic                  w_ale_fall;
    logic                  w_start_rise;
    logic                  w_start_fall;
    logic [ADC_ADDR_W-1:0] w_sel_addr;
    logic [ADC_DATA_W-1:0] w_ch_val;

    adc_state_e            r_state;
    adc_state_e            w_state_nx;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nx;
    logic [ADC_ADDR_W-1:0] r_addr;
    logic [ADC_DATA_W-1:0] r_snap;
    logic [ADC_DATA_W-1:0] w_snap_nx;
    logic [ADC_DATA_W-1:0] r_result;
    logic [ADC_DATA_W-1:0] w_result_nx;
    logic                  r_done;
    logic                  w_done_nx;

    adc_edge_detect u_ale_edge (
        .clk    (clk),
        .reset  (reset),
        .i_d    (bus.ale),
        .o_rise (w_ale_rise),
        .o_fall (w_ale_fall)
    );

    adc_edge_detect u_start_edge (
        .clk    (clk),
        .reset  (reset),
        .i_d    (bus.start),
        .o_rise (w_start_rise),
        .o_fall (w_start_fall)
    );

    // An ALE rise on the START-fall edge must steer that snapshot
    always_comb begin
        w_sel_addr = w_ale_rise ? bus.addr : r_addr;
        w_ch_val   = '0;
        for (int k = 0; k < CH_COUNT; k++) begin
            if (w_sel_addr == ADC_ADDR_W'(k))
                w_ch_val = ch_data[k*ADC_DATA_W +: ADC_DATA_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           r_addr <= '0;
        else if (w_ale_rise) r_addr <= bus.addr;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_snap_nx   = r_snap;
        w_result_nx = r_result;
        w_done_nx   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start_rise) w_state_nx = ARMED;
            end
            ARMED: begin
                if (w_start_fall) begin
                    w_state_nx = CONVERT;
                    w_snap_nx  = w_ch_val;
                    w_cnt_nx   = CNT_LOAD;
                end
            end
            CONVERT: begin
                if (w_start_rise) begin
                    w_state_nx = ARMED;
                end else if (r_cnt == '0) begin
                    w_state_nx  = IDLE;
                    w_result_nx = r_snap;
                    w_done_nx   = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_snap   <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_snap   <= w_snap_nx;
            r_result <= w_result_nx;
            r_done   <= w_done_nx;
        end
    end

    assign bus.eoc      = (r_state == IDLE);
    assign bus.data_out = bus.oe ? r_result : '0;
    assign bus.data_drv = bus.oe;
    assign conv_done    = r_done;

endmodule

// File: tb/tb_adc0808_responder.sv
// Scoreboard bench for adc0808_responder: directed scenarios,
// a 256-step channel sweep and randomized conversions.
module tb_adc0808_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ch_data;
    logic        conv_done;

    adc0808_responder_if bus ();

    adc0808_responder dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ch_data   (ch_data),
        .conv_done (conv_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] m_addr;
    logic [7:0] m_result;
    logic       prev_eoc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] chan(input logic [63:0] d,
                                        input logic [2:0] a);
        return 8'((d >> (int'(a) * 8)) & 64'hFF);
    endfunction

    // Monitor: every conv_done pulse must match the oldest expectation
    initial begin
        exp_t e;
        prev_eoc = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_eoc = 1'b1;
            end else begin
                if (conv_done) begin
                    if (sb.size() == 0) begin
                        chk("spurious_done", 32'(conv_done), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", 32'(bus.data_out),
                            bus.oe ? 32'(e.val) : 0);
                        chk("done_cycle", cyc, e.cyc);
                        chk("eoc_at_done", 32'(bus.eoc), 1);
                        chk("eoc_before_done", 32'(prev_eoc), 0);
                        m_result = e.val;
                    end
                end
                prev_eoc = bus.eoc;
            end
        end
    end

    task automatic push_exp();
        exp_t e;
        e.val = chan(ch_data, m_addr);
        e.cyc = cyc + 65;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        sb.delete();
        m_addr    = '0;
        m_result  = '0;
        bus.start = 1'b0;
        bus.ale   = 1'b0;
        bus.oe    = 1'b1;
        @(negedge clk);
        chk("rst_eoc", 32'(bus.eoc), 1);
        chk("rst_data", 32'(bus.data_out), 0);
        chk("rst_done", 32'(conv_done), 0);
        reset = 1'b0;
    endtask

    // ale_mode: 0 none, 1 with start rise, 2 with start fall
    task automatic conv(input int ale_mode, input logic [2:0] a,
                        input int hold, input int abort_at,
                        input bit chg, input int rst_at, input bit o);
        int n;
        @(negedge clk);
        bus.oe   = o;
        bus.addr = (ale_mode == 1) ? a : 3'($urandom);
        if (ale_mode == 1) begin
            bus.ale = 1'b1;
            m_addr  = a;
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.ale = 1'b0;
        chk("eoc_busy", 32'(bus.eoc), 0);
        repeat (hold) @(negedge clk);
        if (ale_mode == 2) begin
            bus.addr = a;
            bus.ale  = 1'b1;
            m_addr   = a;
        end
        bus.start = 1'b0;
        push_exp();
        @(negedge clk);
        bus.ale = 1'b0;
        if (chg) ch_data = {$urandom, $urandom};
        if (rst_at > 0) begin
            repeat (rst_at - 1) @(negedge clk);
            do_reset();
            @(negedge clk);
            return;
        end
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            bus.start = 1'b1;
            sb.delete(sb.size() - 1);
            @(negedge clk);
            chk("eoc_abort", 32'(bus.eoc), 0);
            chk("gap_data", 32'(bus.data_out), o ? 32'(m_result) : 0);
            repeat (4) @(negedge clk);
            bus.start = 1'b0;
            push_exp();
        end
        n = 0;
        while (!bus.eoc && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("eoc_timeout", 32'(bus.eoc), 1);
    endtask

    initial begin
        reset     = 1'b1;
        bus.ale   = 1'b0;
        bus.start = 1'b0;
        bus.oe    = 1'b1;
        bus.addr  = '0;
        ch_data   = {$urandom, $urandom};
        do_reset();
        chk("rst_drv", 32'(bus.data_drv), 1);

        ch_data[7:0] = 8'hA5;
        conv(1, 3'd0, 0, 0, 1'b0, 0, 1'b1);

        ch_data[31:24] = 8'h3C;
        conv(1, 3'd3, 1, 0, 1'b0, 0, 1'b1);
        conv(0, 3'd5, 0, 0, 1'b0, 0, 1'b1);

        conv(1, 3'd0, 0, 30, 1'b0, 0, 1'b1);

        ch_data[7:0] = 8'h11;
        conv(1, 3'd0, 0, 0, 1'b1, 0, 1'b1);

        conv(1, 3'd0, 0, 0, 1'b0, 20, 1'b1);

        conv(2, 3'd6, 2, 0, 1'b0, 0, 1'b0);
        @(negedge clk);
        bus.oe = 1'b0;
        #1;
        chk("oe_off_data", 32'(bus.data_out), 0);
        chk("oe_off_drv", 32'(bus.data_drv), 0);

        for (int v = 0; v < 256; v++) begin
            ch_data[7:0] = 8'(v);
            conv((v == 0) ? 1 : 0, 3'd0, 0, 0, 1'b0, 0, 1'b1);
            chk("sweep_stream", 32'(m_result), v);
        end

        for (int i = 0; i < 40; i++) begin
            ch_data = {$urandom, $urandom};
            conv(int'($urandom_range(0, 2)), 3'($urandom),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0,
                 1'($urandom),
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 60)) : 0,
                 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
